video2ram: RTL and testbench

Capture side of the line-buffer path: takes the Dreamcast's 12-bit, two-beats-per-pixel digital video with its sync, assembles 24-bit RGB pixels and writes the visible area into the dual-port line-buffer RAM. The HDMI-side timing generator reads that RAM.
- It also measures frame geometry and drives the `line_doubler` and `add_line` mode flags.
- It asserts `starttrigger` once enough lines are buffered for the read side to start safely.

---
 rtl/video2ram_pkg.sv | 27 ++
 rtl/video2ram_if.sv | 13 +
 rtl/video2ram_geometry_detect.sv | 61 ++++++
 rtl/video2ram.sv | 154 +++++++++++++++
 tb/tb_video2ram.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/video2ram_pkg.sv
// Shared constants and types for the Dreamcast capture side of the line buffer.
// Geometry defaults and RAM sizing must stay identical to the HDMI read side.
package video2ram_pkg;

  localparam int DEF_RAM_ADDRESS_BITS    = 14;
  localparam int DEF_BUFFER_SIZE         = 16;
  localparam int DEF_H_ACTIVE            = 640;
  localparam int DEF_V_ACTIVE            = 480;
  localparam int DEF_H_CAPTURE_START     = 96;
  localparam int DEF_V_CAPTURE_START     = 35;
  localparam int DEF_TRIGGER_LINE        = 2;

  // Fewer lines than this per vsync period means 240p/480i, so the read side doubles lines.
  localparam logic [10:0] LINE_DOUBLE_THRESHOLD = 11'd300;
  localparam logic [10:0] COUNT_MAX             = 11'h7ff;

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    ALIGN      = 2'd1,
    CAPTURE    = 2'd2
  } capture_state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == COUNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/video2ram_if.sv
// Write port of the dual-port line-buffer RAM: the capture side drives it, the RAM consumes it.
interface video2ram_if
  import video2ram_pkg::*;
#(
  parameter int ADDR_BITS = DEF_RAM_ADDRESS_BITS
);
  logic [ADDR_BITS-1:0] wraddr;
  logic [23:0]          wrdata;
  logic                 wren;

  modport master (output wraddr, output wrdata, output wren);
  modport slave  (input  wraddr, input  wrdata, input  wren);
endinterface

// File: rtl/video2ram_geometry_detect.sv
// Counts lines between vsync falling edges and derives the line_doubler/add_line mode flags.
// The first vsync after reset only arms the counter, so a partial period never sets a mode.
module video_geometry_detect
  import video2ram_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic vs_fall_i,
  input  logic hs_fall_i,
  output logic line_doubler_o,
  output logic add_line_o,
  output logic mode_changed_o
);

  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic        valid_q, valid_d;
  logic        dbl_q, dbl_d;
  logic        add_q, add_d;
  logic [10:0] len_meas;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      dbl_q   <= 1'b0;
      add_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      dbl_q   <= dbl_d;
      add_q   <= add_d;
    end
  end

  always_comb begin
    // An hsync coinciding with vsync closes the old period rather than opening the new one.
    len_meas = hs_fall_i ? sat_inc(cnt_q) : cnt_q;
    cnt_d    = len_meas;
    len_d    = len_q;
    valid_d  = valid_q;
    dbl_d    = dbl_q;
    add_d    = add_q;
    if (vs_fall_i) begin
      cnt_d   = '0;
      valid_d = 1'b1;
      if (valid_q) begin
        len_d = len_meas;
        dbl_d = (len_meas < LINE_DOUBLE_THRESHOLD);
        add_d = (len_meas == len_q + 11'd1) || (len_q == len_meas + 11'd1);
      end
    end
    mode_changed_o = (dbl_d != dbl_q) || (add_d != add_q);
  end

  assign line_doubler_o = dbl_q;
  assign add_line_o     = add_q;

endmodule

// File: rtl/video2ram.sv
// Dreamcast 12-bit two-beat video capture: assembles 24-bit pixels and writes the visible
// window into the line-buffer ring, raising starttrigger once enough lines are stored.
module video2ram
  import video2ram_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = DEF_RAM_ADDRESS_BITS,
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int H_CAPTURE_START  = DEF_H_CAPTURE_START,
  parameter int V_CAPTURE_START  = DEF_V_CAPTURE_START,
  parameter int BUFFER_SIZE      = DEF_BUFFER_SIZE,
  parameter int TRIGGER_LINE     = DEF_TRIGGER_LINE
)(
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] data,
  input  logic        hsync_n,
  input  logic        vsync_n,
  video2ram_if.master ram,
  output logic        starttrigger,
  output logic        line_doubler,
  output logic        add_line
);

  localparam logic [10:0] X_START  = 11'(H_CAPTURE_START);
  localparam logic [10:0] X_END    = 11'(H_CAPTURE_START + H_ACTIVE);
  localparam logic [10:0] Y_START  = 11'(V_CAPTURE_START);
  localparam logic [10:0] Y_END_P  = 11'(V_CAPTURE_START + V_ACTIVE);
  localparam logic [10:0] Y_END_I  = 11'(V_CAPTURE_START + V_ACTIVE / 2);
  localparam logic [10:0] CX_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] CY_TRIG  = 11'(TRIGGER_LINE);
  localparam logic [10:0] RING     = 11'(BUFFER_SIZE);

  logic [11:0] data_r1_q;
  logic        hs_r1_q, hs_r2_q, vs_r1_q, vs_r2_q;

  capture_state_t              state_q, state_d;
  logic                        phase_q, phase_d;
  logic [11:0]                 beat0_q, beat0_d;
  logic [10:0]                 x_q, x_d, y_q, y_d;
  logic                        first_frame_q, first_frame_d;
  logic                        wren_q, wren_d;
  logic [RAM_ADDRESS_BITS-1:0] wraddr_q, wraddr_d;
  logic [23:0]                 wrdata_q, wrdata_d;
  logic                        trig_hit_q, trig_hit_d;
  logic                        starttrigger_q, starttrigger_d;

  logic        hs_fall, vs_fall, pix_done, in_window, mode_changed;
  logic [10:0] cx, cy, y_end;

  video_geometry_detect u_geometry (
    .clock          (clock),
    .reset          (reset),
    .vs_fall_i      (vs_fall),
    .hs_fall_i      (hs_fall),
    .line_doubler_o (line_doubler),
    .add_line_o     (add_line),
    .mode_changed_o (mode_changed)
  );

  // Syncs clear low so that releasing reset never manufactures a falling edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_r1_q      <= '0;
      hs_r1_q        <= 1'b0;
      hs_r2_q        <= 1'b0;
      vs_r1_q        <= 1'b0;
      vs_r2_q        <= 1'b0;
      state_q        <= WAIT_VSYNC;
      phase_q        <= 1'b0;
      beat0_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      first_frame_q  <= 1'b0;
      wren_q         <= 1'b0;
      wraddr_q       <= '0;
      wrdata_q       <= '0;
      trig_hit_q     <= 1'b0;
      starttrigger_q <= 1'b0;
    end else begin
      data_r1_q      <= data;
      hs_r1_q        <= hsync_n;
      hs_r2_q        <= hs_r1_q;
      vs_r1_q        <= vsync_n;
      vs_r2_q        <= vs_r1_q;
      state_q        <= state_d;
      phase_q        <= phase_d;
      beat0_q        <= beat0_d;
      x_q            <= x_d;
      y_q            <= y_d;
      first_frame_q  <= first_frame_d;
      wren_q         <= wren_d;
      wraddr_q       <= wraddr_d;
      wrdata_q       <= wrdata_d;
      trig_hit_q     <= trig_hit_d;
      starttrigger_q <= starttrigger_d;
    end
  end

  always_comb begin
    hs_fall  = hs_r2_q & ~hs_r1_q;
    vs_fall  = vs_r2_q & ~vs_r1_q;
    // A beat-1 sample landing on the hsync edge belongs to no pixel of the new line.
    pix_done = phase_q & ~hs_fall;
    phase_d  = hs_fall ? 1'b0 : ~phase_q;
    beat0_d  = phase_q ? beat0_q : data_r1_q;

    x_d = x_q;
    if (hs_fall)       x_d = '0;
    else if (pix_done) x_d = sat_inc(x_q);

    y_d = y_q;
    if (vs_fall)      y_d = '0;
    else if (hs_fall) y_d = sat_inc(y_q);

    state_d       = state_q;
    first_frame_d = first_frame_q;
    case (state_q)
      WAIT_VSYNC: if (vs_fall) state_d = ALIGN;
      ALIGN: if (hs_fall) begin
        state_d       = CAPTURE;
        first_frame_d = 1'b1;
      end
      CAPTURE: if (vs_fall) first_frame_d = 1'b0;
      default: state_d = WAIT_VSYNC;
    endcase
    if (mode_changed) begin
      state_d       = WAIT_VSYNC;
      first_frame_d = 1'b0;
    end

    y_end     = line_doubler ? Y_END_I : Y_END_P;
    in_window = (x_q >= X_START) && (x_q < X_END) && (y_q >= Y_START) && (y_q < y_end);
    cx        = x_q - X_START;
    cy        = y_q - Y_START;

    wren_d   = pix_done && (state_q == CAPTURE) && in_window;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    if (wren_d) begin
      wraddr_d = RAM_ADDRESS_BITS'(32'(cy % RING) * 32'(H_ACTIVE) + 32'(cx));
      wrdata_d = {beat0_q, data_r1_q};
    end

    trig_hit_d     = wren_d && first_frame_q && (cx == CX_LAST) && (cy == CY_TRIG) && !mode_changed;
    starttrigger_d = mode_changed ? 1'b0 : (starttrigger_q | trig_hit_q);
  end

  assign ram.wren     = wren_q;
  assign ram.wraddr   = wraddr_q;
  assign ram.wrdata   = wrdata_q;
  assign starttrigger = starttrigger_q;

endmodule

// File: tb/tb_video2ram.sv
// Directed bench for video2ram: drives 480p frames and 263/262 fields with short blanking
// lines, logs every RAM write and checks addresses, data, counts and flags against constants.
module tb_video2ram;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] data;
  logic        hsync_n, vsync_n;
  logic        starttrigger, line_doubler, add_line;

  video2ram_if ram_if ();

  video2ram dut (
    .clock        (clock),
    .reset        (reset),
    .data         (data),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .ram          (ram_if),
    .starttrigger (starttrigger),
    .line_doubler (line_doubler),
    .add_line     (add_line)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [13:0] addr;
    logic [23:0] wdata;
    logic [31:0] smp;
  } wr_t;

  wr_t         wr_log[$];
  logic [31:0] trig_rise[$];
  logic [31:0] smp_n = 0;
  logic        prev_wren = 1'b0, prev_trig = 1'b0, prev_dbl = 1'b0, prev_add = 1'b0;
  int          b2b = 0, flag_bad = 0;

  always @(negedge clock) begin
    if (ram_if.wren) wr_log.push_back('{ram_if.wraddr, ram_if.wrdata, smp_n});
    if (starttrigger && !prev_trig) trig_rise.push_back(smp_n);
    if (ram_if.wren && prev_wren) b2b <= b2b + 1;
    if (((line_doubler != prev_dbl) || (add_line != prev_add)) && starttrigger) flag_bad <= flag_bad + 1;
    prev_wren <= ram_if.wren;
    prev_trig <= starttrigger;
    prev_dbl  <= line_doubler;
    prev_add  <= add_line;
    smp_n     <= smp_n + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d (0x%0h)", tag, got, got);
    end
  endtask

  task automatic check_outputs_zero(input string where);
    chk({where, "_wren"},   32'(ram_if.wren),   32'd0);
    chk({where, "_wraddr"}, 32'(ram_if.wraddr), 32'd0);
    chk({where, "_wrdata"}, 32'(ram_if.wrdata), 32'd0);
    chk({where, "_trig"},   32'(starttrigger),  32'd0);
    chk({where, "_dbl"},    32'(line_doubler),  32'd0);
    chk({where, "_add"},    32'(add_line),      32'd0);
  endtask

  // Pixel payload tags its own source line and column; one pixel carries the beat test pattern.
  function automatic logic [23:0] pix(input int y, input int x);
    logic [9:0]  yy = 10'(y);
    logic [11:0] xx = 12'(x);
    if (y == 38 && x == 100) return 24'hABCDEF;
    return {2'b01, yy, xx};
  endfunction

  function automatic int find_wr(input int from, input logic [23:0] d);
    for (int i = from; i < wr_log.size(); i++)
      if (wr_log[i].wdata == d) return i;
    return -1;
  endfunction

  function automatic logic [31:0] addr_of(input int from, input logic [23:0] d);
    int idx = find_wr(from, d);
    return (idx < 0) ? 32'hFFFF_FFFF : 32'(wr_log[idx].addr);
  endfunction

  task automatic cyc(input logic [11:0] d, input logic hs, input logic vs);
    @(negedge clock);
    if (!reset) begin
      check_outputs_zero("midline_rst");
      reset = 1'b1;
    end
    data    = d;
    hsync_n = hs;
    vsync_n = vs;
  endtask

  task automatic drive_line(input int y, input int npix, input int rst_x);
    logic vs = (y < 3) ? 1'b0 : 1'b1;
    cyc(12'h000, 1'b0, vs);
    for (int x = 0; x < npix; x++) begin
      logic [23:0] p = pix(y, x);
      cyc(p[23:12], (x == 0) ? 1'b0 : 1'b1, vs);
      if (x == rst_x) reset = 1'b0;
      cyc(p[11:0], 1'b1, vs);
    end
    cyc(12'h000, 1'b1, vs);
  endtask

  // mode 0: full 480p test frame; 1: reset mid line 35; 2: lines 35..37 full; 3: all short
  function automatic int npix_for(input int mode, input int y);
    case (mode)
      0: begin
        if (y == 35 || y == 36 || y == 37 || y == 50 || y == 51) return 736;
        if (y == 38) return 102;
        return 2;
      end
      1: return (y == 35) ? 736 : 2;
      2: return (y >= 35 && y <= 37) ? 736 : 2;
      default: return 2;
    endcase
  endfunction

  task automatic drive_frame(input int nlines, input int mode, input int rst_x);
    for (int y = 0; y < nlines; y++)
      drive_line(y, npix_for(mode, y), (y == 35) ? rst_x : -1);
  endtask

  int m;
  int idx;
  int hits;

  initial begin
    reset   = 1'b0;
    data    = 12'h000;
    hsync_n = 1'b1;
    vsync_n = 1'b1;
    repeat (4) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Frame A: 525-line 480p with test lines
    m = wr_log.size();
    drive_frame(525, 0, -1);
    chk("A_write_count", 32'(wr_log.size() - m), 32'd3206);
    chk("A_first_addr",  32'(wr_log[m].addr),    32'd0);
    chk("A_first_data",  32'(wr_log[m].wdata),   32'h423060);
    chk("A_px5_cy3_addr",   addr_of(m, pix(38, 101)), 32'd1925);
    chk("A_beat_addr",      addr_of(m, 24'hABCDEF),   32'd1924);
    hits = 0;
    for (int i = m; i < wr_log.size(); i++) if (wr_log[i].wdata == 24'hABCDEF) hits++;
    chk("A_beat_hits", 32'(hits), 32'd1);
    chk("A_cy15_last_addr", addr_of(m, pix(50, 735)), 32'd10239);
    chk("A_cy16_first_addr", addr_of(m, pix(51, 96)), 32'd0);
    chk("A_cy16_last_addr", addr_of(m, pix(51, 735)), 32'd639);
    chk("A_trig_rises", 32'(trig_rise.size()), 32'd1);
    idx = find_wr(m, pix(37, 735));
    if (idx >= 0 && trig_rise.size() > 0)
      chk("A_trig_delay", trig_rise[0] - wr_log[idx].smp, 32'd1);
    else
      chk("A_trig_delay_found", 32'd0, 32'd1);
    chk("A_trig_level", 32'(starttrigger), 32'd1);

    // Frame B: reset asserted at cx=300 of the first captured line
    m = wr_log.size();
    drive_frame(525, 1, 396);
    chk("B_write_count", 32'(wr_log.size() - m), 32'd299);
    chk("B_trig_level",  32'(starttrigger), 32'd0);

    // Frame C: capture resumes only after vsync then hsync
    m = wr_log.size();
    drive_frame(525, 2, -1);
    chk("C_write_count", 32'(wr_log.size() - m), 32'd1920);
    chk("C_first_addr",  (wr_log.size() > m) ? 32'(wr_log[m].addr)  : 32'hFFFF_FFFF, 32'd0);
    chk("C_first_data",  (wr_log.size() > m) ? 32'(wr_log[m].wdata) : 32'hFFFF_FFFF, 32'h423060);
    chk("C_trig_level",  32'(starttrigger), 32'd1);
    chk("C_trig_rises",  32'(trig_rise.size()), 32'd2);

    // Alternating 263/262-line fields
    drive_frame(263, 3, -1);
    chk("F1_dbl",  32'(line_doubler), 32'd0);
    chk("F1_add",  32'(add_line),     32'd0);
    chk("F1_trig", 32'(starttrigger), 32'd1);
    drive_frame(262, 3, -1);
    chk("F2_dbl",  32'(line_doubler), 32'd1);
    chk("F2_add",  32'(add_line),     32'd0);
    chk("F2_trig", 32'(starttrigger), 32'd0);
    m = wr_log.size();
    drive_frame(263, 2, -1);
    chk("F3_dbl",  32'(line_doubler), 32'd1);
    chk("F3_add",  32'(add_line),     32'd1);
    chk("F3_trig", 32'(starttrigger), 32'd0);
    chk("F3_write_count", 32'(wr_log.size() - m), 32'd0);
    m = wr_log.size();
    drive_frame(262, 2, -1);
    chk("F4_dbl",  32'(line_doubler), 32'd1);
    chk("F4_add",  32'(add_line),     32'd1);
    chk("F4_trig", 32'(starttrigger), 32'd1);
    chk("F4_write_count", 32'(wr_log.size() - m), 32'd1920);
    chk("F4_first_addr", (wr_log.size() > m) ? 32'(wr_log[m].addr) : 32'hFFFF_FFFF, 32'd0);

    repeat (2) @(negedge clock);
    chk("wren_back_to_back", 32'(b2b), 32'd0);
    chk("trig_clear_with_flag", 32'(flag_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
